slim_motion: RTL and testbench

//  Patrol controller for one slime enemy. Walks the slime left/right between two
//  x bounds on a fixed floor and stops it while the freeze detector holds `frozen`.
//  On release it runs a thaw delay, then resumes walking in its saved direction.
//  Its x_slim/y_slim outputs feed the freeze detector and the sprite renderer.
//  The detector's `frozen` output comes back into this block.

---
 rtl/slim_motion.sv | 113 +++++++++++
 tb/tb_slim_motion.sv | 122 ++++++++++++
 2 files changed

// File: rtl/slim_motion.sv
// Patrol controller for one slime enemy: walks between two x bounds, pauses at each bound,
// stops while frozen, then runs a blinking thaw delay before resuming in its saved direction.
module slim_motion #(
    parameter logic [9:0]  X_MIN      = 10'd40,
    parameter logic [9:0]  X_MAX      = 10'd500,
    parameter logic [8:0]  Y_FLOOR    = 9'd300,
    parameter logic [9:0]  STEP       = 10'd2,
    parameter logic [23:0] STEP_DIV   = 24'd1000000,
    parameter logic [3:0]  TURN_TICKS = 4'd8,
    parameter logic [3:0]  THAW_TICKS = 4'd12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       frozen,
    output logic [9:0] x_slim,
    output logic [8:0] y_slim,
    output logic       dir,
    output logic       moving,
    output logic       blink
);

    typedef enum logic [2:0] {WALK_R, WALK_L, TURN, FROZEN, THAW} state_t;

    state_t      state, state_nxt;
    logic [23:0] tcnt;
    logic        tick;
    logic [3:0]  pcnt, pcnt_nxt, pcnt_inc;
    logic [9:0]  x_nxt;
    logic        dir_nxt, moving_nxt, blink_nxt;
    logic [10:0] x_inc;

    assign tick     = en && (tcnt == STEP_DIV - 24'd1);
    assign pcnt_inc = pcnt + 4'd1;
    // 11-bit sum so a right step near the top of the range cannot wrap
    assign x_inc    = {1'b0, x_slim} + {1'b0, STEP};
    assign y_slim   = Y_FLOOR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WALK_R;
            x_slim <= X_MIN;
            dir    <= 1'b0;
            pcnt   <= 4'd0;
            tcnt   <= 24'd0;
            moving <= 1'b0;
            blink  <= 1'b0;
        end else begin
            state  <= state_nxt;
            x_slim <= x_nxt;
            dir    <= dir_nxt;
            pcnt   <= pcnt_nxt;
            tcnt   <= (!en || tick) ? 24'd0 : tcnt + 24'd1;
            moving <= moving_nxt;
            blink  <= blink_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_slim;
        dir_nxt   = dir;
        pcnt_nxt  = pcnt;
        if (en) begin
            // a freeze request pre-empts any move scheduled for this cycle
            if (frozen && state != FROZEN) begin
                state_nxt = FROZEN;
            end else begin
                case (state)
                    FROZEN: if (!frozen) begin
                        state_nxt = THAW;
                        pcnt_nxt  = 4'd0;
                    end
                    THAW, TURN: if (tick) begin
                        pcnt_nxt = pcnt_inc;
                        if (pcnt_inc == ((state == THAW) ? THAW_TICKS : TURN_TICKS)) begin
                            state_nxt = dir ? WALK_L : WALK_R;
                            pcnt_nxt  = 4'd0;
                        end
                    end
                    WALK_R: if (tick) begin
                        if (x_inc >= {1'b0, X_MAX}) begin
                            x_nxt     = X_MAX;
                            dir_nxt   = 1'b1;
                            state_nxt = TURN;
                            pcnt_nxt  = 4'd0;
                        end else begin
                            x_nxt = x_inc[9:0];
                        end
                    end
                    WALK_L: if (tick) begin
                        // compare before subtracting so x never underflows
                        if ({1'b0, x_slim} <= {1'b0, X_MIN} + {1'b0, STEP}) begin
                            x_nxt     = X_MIN;
                            dir_nxt   = 1'b0;
                            state_nxt = TURN;
                            pcnt_nxt  = 4'd0;
                        end else begin
                            x_nxt = x_slim - STEP;
                        end
                    end
                    default: state_nxt = WALK_R;
                endcase
            end
        end
    end

    always_comb begin
        moving_nxt = en && (state_nxt == WALK_R || state_nxt == WALK_L);
        blink_nxt  = (state_nxt == THAW) && pcnt_nxt[0];
    end

endmodule

// File: tb/tb_slim_motion.sv
// Directed bench for slim_motion with a 4-cycle tick and a short 40..50 patrol range.
module tb_slim_motion;

    logic       clk = 1'b0;
    logic       rst_n, en, frozen;
    logic [9:0] x_slim;
    logic [8:0] y_slim;
    logic       dir, moving, blink;
    int         errs = 0;
    int         nchk = 0;

    slim_motion #(
        .X_MIN(10'd40), .X_MAX(10'd50), .Y_FLOOR(9'd300), .STEP(10'd2),
        .STEP_DIV(24'd4), .TURN_TICKS(4'd2), .THAW_TICKS(4'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frozen(frozen),
        .x_slim(x_slim), .y_slim(y_slim), .dir(dir), .moving(moving), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, then park on the falling edge to sample / drive
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; frozen = 1'b0;
        step(2);
        chk("rst_x", x_slim, 40);
        chk("rst_y", y_slim, 300);
        chk("rst_dir", dir, 0);
        chk("rst_moving", moving, 0);
        chk("rst_blink", blink, 0);

        // 1: walk right to the bound, pause two ticks, walk back
        rst_n = 1'b1; en = 1'b1;
        step(4); chk("t1_x42", x_slim, 42); chk("t1_mov", moving, 1);
        step(4); chk("t1_x44", x_slim, 44);
        step(4); chk("t1_x46", x_slim, 46);
        step(4); chk("t1_x48", x_slim, 48);
        step(4); chk("t1_x50", x_slim, 50); chk("t1_dir1", dir, 1); chk("t1_turn_mov", moving, 0);
        step(4); chk("t1_turn_x", x_slim, 50);
        step(4); chk("t1_walkl_mov", moving, 1); chk("t1_walkl_x", x_slim, 50);
        step(4); chk("t1_x48l", x_slim, 48);

        // 2: walk left down to the lower bound
        step(4); chk("t2_x46", x_slim, 46);
        step(4); chk("t2_x44", x_slim, 44);
        step(4); chk("t2_x42", x_slim, 42);
        step(4); chk("t2_x40", x_slim, 40); chk("t2_dir0", dir, 0); chk("t2_turn_mov", moving, 0);
        step(4); chk("t2_turn_x", x_slim, 40);
        step(4); chk("t2_walkr_x", x_slim, 40); chk("t2_walkr_mov", moving, 1);
        step(4); chk("t2_x42r", x_slim, 42);
        step(4); chk("t2_x44r", x_slim, 44);

        // 3: freeze coincident with a tick at x=44
        step(3); frozen = 1'b1;
        step(1); chk("t3_x_hold", x_slim, 44); chk("t3_mov", moving, 0);
        step(20); chk("t3_x_long", x_slim, 44); chk("t3_dir", dir, 0);

        // 4: thaw with blink, then resume right
        frozen = 1'b0;
        step(1); chk("t4_blink0", blink, 0); chk("t4_mov", moving, 0);
        step(3); chk("t4_blink_t1", blink, 1); chk("t4_x_t1", x_slim, 44);
        step(4); chk("t4_blink_t2", blink, 0);
        step(4); chk("t4_walk_mov", moving, 1); chk("t4_walk_blink", blink, 0); chk("t4_walk_x", x_slim, 44);
        step(4); chk("t4_x46", x_slim, 46);
        frozen = 1'b1;
        step(4); chk("t4_fz2_x", x_slim, 46); chk("t4_fz2_mov", moving, 0);
        frozen = 1'b0;
        step(4); chk("t4_th2_b1", blink, 1);
        step(4); chk("t4_th2_b0", blink, 0);
        frozen = 1'b1;
        step(4); chk("t4_refz_blink", blink, 0); chk("t4_refz_mov", moving, 0); chk("t4_refz_x", x_slim, 46);
        frozen = 1'b0;
        step(4); chk("t4_th3_b1", blink, 1);
        step(4); chk("t4_th3_b0", blink, 0);
        step(4); chk("t4_th3_mov", moving, 1);
        step(4); chk("t4_x48", x_slim, 48);

        // 5: pause mid-walk, then mid-turn
        step(2); en = 1'b0;
        step(10); chk("t5_x_hold", x_slim, 48); chk("t5_mov_off", moving, 0);
        en = 1'b1;
        step(3); chk("t5_no_early", x_slim, 48);
        step(1); chk("t5_x50", x_slim, 50); chk("t5_dir1", dir, 1);
        step(4); chk("t5_turn1", moving, 0);
        en = 1'b0;
        step(7);
        en = 1'b1;
        step(3); chk("t5_turn_hold_x", x_slim, 50); chk("t5_turn_hold_mov", moving, 0);
        step(1); chk("t5_resume_mov", moving, 1); chk("t5_resume_x", x_slim, 50);

        // 6: async reset mid-turn
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(20); chk("t6_x50", x_slim, 50); chk("t6_dir1", dir, 1);
        step(4); chk("t6_turn_mov", moving, 0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t6_async_x", x_slim, 40);
        chk("t6_async_dir", dir, 0);
        chk("t6_async_mov", moving, 0);
        @(negedge clk); rst_n = 1'b1;
        step(4); chk("t6_after_x", x_slim, 42); chk("t6_after_mov", moving, 1); chk("t6_after_dir", dir, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
